// File: rtl/restoring_div_ctrl.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// start/done handshake, registered results held until the next completion.
module restoring_div_ctrl #(
    parameter int                 WIDTH    = 4,
    parameter logic [WIDTH-1:0]   DBZ_QUOT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_work_q, quo_work_d;
    logic [WIDTH-1:0] div_work_q, div_work_d;
    logic [WIDTH-1:0] rem_work_q, rem_work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            quo_work_q  <= '0;
            div_work_q  <= '0;
            rem_work_q  <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_work_q  <= quo_work_d;
            div_work_q  <= div_work_d;
            rem_work_q  <= rem_work_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // The partial remainder stays below the divisor, so its extra MSB is always
    // zero and only WIDTH bits are stored; the subtraction itself is WIDTH+1 wide.
    always_comb begin
        shifted  = {rem_work_q, quo_work_q[WIDTH-1]};
        diff     = shifted - {1'b0, div_work_q};
        borrow   = diff[WIDTH];
        quo_next = {quo_work_q[WIDTH-2:0], ~borrow};
        rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

        state_d     = state_q;
        quo_work_d  = quo_work_q;
        div_work_d  = div_work_q;
        rem_work_d  = rem_work_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_work_d = dividend;
                    div_work_d = divisor;
                    rem_work_d = '0;
                    cnt_d      = '0;
                    if (divisor == '0) begin
                        quotient_d  = DBZ_QUOT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                quo_work_d = quo_next;
                rem_work_d = rem_next;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Scoreboard bench for restoring_div_ctrl: stimulus pushes expected results from
// plain integer division, a forked monitor pops and compares on every done pulse.
module tb_restoring_div_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             z;
    } exp_t;

    exp_t sbQueue[$];
    exp_t lastExp;
    int   checks;
    int   errors;

    restoring_div_ctrl #(.WIDTH(WIDTH), .DBZ_QUOT(4'hF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned division, with the divide-by-zero convention.
    function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = 4'hF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = WIDTH'(int'(a) / int'(b));
            e.r = WIDTH'(int'(a) % int'(b));
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Pops an expectation on each done; otherwise the results must hold.
    task automatic runMonitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lastExp.q = '0;
                lastExp.r = '0;
                lastExp.z = 1'b0;
            end else if (done) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected done", 1, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("quotient", int'(quotient), int'(e.q));
                    checkOutput("remainder", int'(remainder), int'(e.r));
                    checkOutput("div_by_zero", int'(div_by_zero), int'(e.z));
                    lastExp = e;
                end
            end else begin
                checkOutput("hold quotient", int'(quotient), int'(lastExp.q));
                checkOutput("hold remainder", int'(remainder), int'(lastExp.r));
                checkOutput("hold div_by_zero", int'(div_by_zero), int'(lastExp.z));
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit hold, input bit interfere);
        int expLat;
        int lat;
        bit seen;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sbQueue.push_back(refModel(a, b));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        expLat = (b == 0) ? 1 : WIDTH + 1;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            checkOutput("busy during op", int'(busy), 1);
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
            if (interfere && i == 2) begin
                start    = 1'b1;
                dividend = 4'd15;
                divisor  = 4'd15;
            end
            if (interfere && i == 3 && !hold) start = 1'b0;
        end
        checkOutput("done seen", int'(seen), 1);
        checkOutput("latency", lat, expLat);
        @(negedge clk);
        checkOutput("busy idle gap", int'(busy), 0);
        checkOutput("done single pulse", int'(done), 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        lastExp.q = '0;
        lastExp.r = '0;
        lastExp.z = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        fork
            runMonitor();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset quotient", int'(quotient), 0);
        checkOutput("reset remainder", int'(remainder), 0);
        checkOutput("reset div_by_zero", int'(div_by_zero), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(4'd13, 4'd3, 1'b0, 1'b0);
        applyStimulus(4'd15, 4'd1, 1'b0, 1'b0);
        applyStimulus(4'd2, 4'd7, 1'b0, 1'b0);
        applyStimulus(4'd5, 4'd0, 1'b0, 1'b0);
        applyStimulus(4'd9, 4'd2, 1'b0, 1'b1);

        // Abort 14/3 in its second iteration cycle; results must clear, not revert.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort quotient", int'(quotient), 0);
        checkOutput("abort remainder", int'(remainder), 0);
        checkOutput("abort div_by_zero", int'(div_by_zero), 0);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        sbQueue.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'd14, 4'd3, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom_range(0, 15)), 1'b0, 1'b0);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(WIDTH'(a), WIDTH'(b), 1'b1, 1'b0);
            end
        end
        start = 1'b0;

        repeat (10) @(negedge clk);
        checkOutput("scoreboard drained", sbQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
